vga_stream_tx: RTL and testbench
================================

Name: vga_stream_tx

Overview:
- VGA timing transmitter for the pixel-clock domain. It generates the sync pulses, the H/V counters and the blanking that the classifier path consumes.
- It also requests pixels from an upstream source (frame buffer or camera FIFO) and forwards them as aligned RGB, filling any pixel the source fails to deliver.
- Blanking is placed at the start of each line and frame: active x = H_CNT − H_BLANK, active y = V_CNT − V_BLANK. This matches the offsets used by the contour/classifier path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in clocks
- H_SYNC, 96, horizontal sync width, in clocks
- H_BP, 48, horizontal back porch, in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- FILL_RGB, 24'hFF00FF, colour driven on underflowed active pixels

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- iVGA_R  in  8  pixel red from the source
- iVGA_G  in  8  pixel green from the source
- iVGA_B  in  8  pixel blue from the source
- iRGB_VALID  in  1  source asserts this when iVGA_R/G/B hold the requested pixel
- oREQ  out  1  pixel request; the source must answer on the next cycle
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high during active video
- VGA_H_CNT  out  13  horizontal count, 0 to H_TOTAL−1
- VGA_V_CNT  out  13  vertical count, 0 to V_TOTAL−1
- oVGA_R  out  8  output red
- oVGA_G  out  8  output green
- oVGA_B  out  8  output blue
- oFRAME_START  out  1  one-clock pulse, aligned with counter output (0,0)
- oUNDERFLOW  out  1  sticky: at least one active pixel was filled this frame

Behaviour:
- Derived constants:
  - H_BLANK = H_FP + H_SYNC + H_BP (default 160); H_TOTAL = H_BLANK + H_ACTIVE (default 800).
  - V_BLANK = V_FP + V_SYNC + V_BP (default 45); V_TOTAL = V_BLANK + V_ACTIVE (default 525).
- Internal counters hc, vc (13 bits each):
  - hc increments every clock and wraps H_TOTAL−1 → 0.
  - On each hc wrap, vc increments and wraps V_TOTAL−1 → 0.
  - Both counters wrap together at (H_TOTAL−1, V_TOTAL−1) → (0,0).
- Line and frame order within blanking is front porch, then sync, then back porch.
  - Internal hsync = H_FP ≤ hc < H_FP+H_SYNC.
  - Internal vsync = V_FP ≤ vc < V_FP+V_SYNC, evaluated per whole line.
- active = (hc ≥ H_BLANK) && (vc ≥ V_BLANK).
- oREQ = active, decoded from the internal counter registers.
- Stage-1 registers all update every clock from stage-0 (hc, vc):
  - VGA_H_CNT = hc, VGA_V_CNT = vc
  - VGA_HS = ~hsync, VGA_VS = ~vsync
  - VGA_BLANK_N = active
  - oFRAME_START = (hc==0 && vc==0)
- Latency: every timing output lags the internal counters by exactly one clock. A request issued in cycle t is answered by the source in cycle t+1, which is the cycle in which the registered counters show that pixel.
- RGB output, combinational from the stage-1 registers and the inputs:
  - VGA_BLANK_N=1 and iRGB_VALID=1 → pass iVGA_R/G/B through.
  - VGA_BLANK_N=1 and iRGB_VALID=0 → drive FILL_RGB.
  - VGA_BLANK_N=0 → drive 0, and iRGB_VALID is ignored.
- Underflow:
  - oUNDERFLOW sets on the clock edge after any cycle with VGA_BLANK_N=1 and iRGB_VALID=0.
  - It clears on the edge where oFRAME_START asserts.
  - If a set condition coincides with that clear edge, set wins.
- Reset (rst high at a clock edge, including mid-frame):
  - hc=vc=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_H_CNT=0, VGA_V_CNT=0.
  - oREQ=0, oFRAME_START=0, oUNDERFLOW=0, oVGA_R/G/B=0.
  - oREQ is forced to 0 while rst is high.
- After reset:
  - On the first edge with rst=0, the outputs load (0,0) and oFRAME_START=1; the internal counters advance to (1,0).
  - A mid-frame reset abandons the current frame; no partial-frame state survives.
- Counter-based end-of-frame detection (~HS && ~VS) asserts only during vertical sync lines while HS is low. This gives exactly V_SYNC pulses per frame, one per sync line.
- Parameters are required to give H_TOTAL and V_TOTAL < 8192; no runtime checks are made.

Test Plan:
- Reset, then run one full frame (420000 clocks at defaults) → oFRAME_START exactly twice, 420000 clocks apart. The H_CNT sequence is 0..799 on every line, and the V_CNT sequence is 0..524.
- Sample one line → VGA_HS low for H_CNT 16..111 (96 clocks). VGA_BLANK_N high for H_CNT 160..799 only when V_CNT ≥ 45. VGA_VS low only for V_CNT 10..11.
- Source answers every oREQ with iRGB_VALID=1 and RGB = low byte of the request index → output RGB matches with zero skew. There are 307200 active pixels per frame, and oUNDERFLOW stays 0.
- Drop iRGB_VALID for the pixel at (200,50) → that pixel outputs FF/00/FF and oUNDERFLOW rises on the next clock. It holds until the next oFRAME_START edge, then reads 0.
- Drive iRGB_VALID=1 with RGB=AA/BB/CC during blanking → oVGA_R/G/B=0 and oUNDERFLOW stays 0.
- Assert rst for 3 clocks at (H_CNT=400, V_CNT=300) → all outputs take their reset values on the first reset edge. On the first edge after release the outputs show (0,0) with oFRAME_START=1, and oUNDERFLOW=0.

Source files
------------

// File: rtl/vga_stream_tx.sv
// VGA timing transmitter: blanking-first line/frame timing, pixel request
// toward an upstream source, and aligned RGB output with underflow fill.
module vga_stream_tx #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic [23:0] FILL_RGB = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  iVGA_R,
    input  logic [7:0]  iVGA_G,
    input  logic [7:0]  iVGA_B,
    input  logic        iRGB_VALID,
    output logic        oREQ,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [12:0] VGA_H_CNT,
    output logic [12:0] VGA_V_CNT,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oFRAME_START,
    output logic        oUNDERFLOW
);

    localparam int unsigned CW      = 13;
    localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int unsigned V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;

    // Stage 0: raster counters
    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;

    // Stage 1: registered timing outputs
    logic [CW-1:0] h_cnt_q, v_cnt_q;
    logic          hs_q, vs_q, blank_n_q, frame_start_q;
    logic          underflow_q, underflow_d;

    // Stage-0 decodes
    logic hsync_c, vsync_c, active_c, frame_c;

    // Raster counter next-state: hc wraps every line, vc steps on each hc wrap
    always_comb begin
        hc_d = hc_q + CW'(1);
        vc_d = vc_q;
        if (hc_q == CW'(H_TOTAL - 1)) begin
            hc_d = '0;
            if (vc_q == CW'(V_TOTAL - 1)) begin
                vc_d = '0;
            end else begin
                vc_d = vc_q + CW'(1);
            end
        end
    end

    // Sync, active and frame-start decode from the stage-0 counters
    always_comb begin
        hsync_c  = (hc_q >= CW'(H_FP)) && (hc_q < CW'(H_FP + H_SYNC));
        vsync_c  = (vc_q >= CW'(V_FP)) && (vc_q < CW'(V_FP + V_SYNC));
        active_c = (hc_q >= CW'(H_BLANK)) && (vc_q >= CW'(V_BLANK));
        frame_c  = (hc_q == '0) && (vc_q == '0);
    end

    // Underflow is sticky within a frame; a fill on the clearing edge still sets it
    always_comb begin
        underflow_d = underflow_q;
        if (blank_n_q && !iRGB_VALID) begin
            underflow_d = 1'b1;
        end else if (frame_c) begin
            underflow_d = 1'b0;
        end
    end

    // Raster counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Stage-1 timing registers, one clock behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= hc_q;
            v_cnt_q       <= vc_q;
            hs_q          <= ~hsync_c;
            vs_q          <= ~vsync_c;
            blank_n_q     <= active_c;
            frame_start_q <= frame_c;
        end
    end

    // Underflow flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    // Pixel output: pass-through, fill on missing data, black in blanking
    always_comb begin
        {oVGA_R, oVGA_G, oVGA_B} = 24'h0;
        if (blank_n_q) begin
            if (iRGB_VALID) begin
                {oVGA_R, oVGA_G, oVGA_B} = {iVGA_R, iVGA_G, iVGA_B};
            end else begin
                {oVGA_R, oVGA_G, oVGA_B} = FILL_RGB;
            end
        end
    end

    // Request leads the displayed pixel by one clock; held off during reset
    assign oREQ         = active_c & ~rst;
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_n_q;
    assign VGA_H_CNT    = h_cnt_q;
    assign VGA_V_CNT    = v_cnt_q;
    assign oFRAME_START = frame_start_q;
    assign oUNDERFLOW   = underflow_q;

endmodule

// File: tb/tb_vga_stream_tx.sv
// Self-checking bench for vga_stream_tx using a reduced raster
// (24 x 11 total, 16 x 6 active) so full frames stay short.
module tb_vga_stream_tx;

    localparam int unsigned H_ACTIVE = 16;
    localparam int unsigned H_FP     = 2;
    localparam int unsigned H_SYNC   = 3;
    localparam int unsigned H_BP     = 3;
    localparam int unsigned V_ACTIVE = 6;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 2;
    localparam int H_BLANK = 8;
    localparam int H_TOTAL = 24;
    localparam int V_BLANK = 5;
    localparam int V_TOTAL = 11;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic        clk;
    logic        rst;
    logic [7:0]  iVGA_R, iVGA_G, iVGA_B;
    logic        iRGB_VALID;
    logic        oREQ;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [12:0] VGA_H_CNT, VGA_V_CNT;
    logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
    logic        oFRAME_START;
    logic        oUNDERFLOW;

    vga_stream_tx #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .FILL_RGB(24'hFF00FF)
    ) dut (
        .clk(clk), .rst(rst),
        .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
        .iRGB_VALID(iRGB_VALID),
        .oREQ(oREQ),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_H_CNT(VGA_H_CNT), .VGA_V_CNT(VGA_V_CNT),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oFRAME_START(oFRAME_START), .oUNDERFLOW(oUNDERFLOW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nh = 0, nv = 0;   // position the next edge will display
    int mh = 0, mv = 0;   // position displayed after the last edge
    int src_idx = 0;      // running index of answered requests

    typedef struct {
        int          h;
        int          v;
        bit          valid;
        logic [23:0] rgb;
        bit          hs;
        bit          vs;
        bit          bn;
        logic [23:0] exp_rgb;
        bit          uf;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at (%0d,%0d): got %0h expected %0h", nm, mh, mv, act, exp);
        end
    endtask

    function automatic bit hs_e(input int h);
        return !(h >= int'(H_FP) && h < int'(H_FP + H_SYNC));
    endfunction

    function automatic bit vs_e(input int v);
        return !(v >= int'(V_FP) && v < int'(V_FP + V_SYNC));
    endfunction

    function automatic bit act_e(input int h, input int v);
        return (h >= H_BLANK) && (v >= V_BLANK);
    endfunction

    function automatic logic [23:0] src_rgb(input int idx);
        logic [7:0] b;
        b = 8'(idx);
        return {b, ~b, b ^ 8'h5A};
    endfunction

    // One clock: check the request, then answer it (or drive an override)
    task automatic step(input bit ovr, input bit ov_valid, input logic [23:0] ov_rgb);
        logic req_now;
        req_now = oREQ;
        chk("oREQ", 64'(req_now), 64'(act_e(nh, nv)));
        @(posedge clk);
        #1;
        mh = nh;
        mv = nv;
        if (nh == H_TOTAL - 1) begin
            nh = 0;
            nv = (nv == V_TOTAL - 1) ? 0 : nv + 1;
        end else begin
            nh = nh + 1;
        end
        if (ovr) begin
            iRGB_VALID = ov_valid;
            {iVGA_R, iVGA_G, iVGA_B} = ov_rgb;
        end else begin
            iRGB_VALID = req_now;
            {iVGA_R, iVGA_G, iVGA_B} = src_rgb(src_idx);
            if (req_now) src_idx++;
        end
        #1;
    endtask

    task automatic goto_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(nh == h && nv == v) && n < 2 * FRAME) begin
            step(1'b0, 1'b0, 24'h0);
            n++;
        end
        chk("goto_bound", 64'(n < 2 * FRAME), 64'd1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        iRGB_VALID = 1'b1;
        {iVGA_R, iVGA_G, iVGA_B} = 24'hAABBCC;
        #1;
        chk("req_in_reset", 64'(oREQ), 64'd0);
        @(posedge clk);
        #2;
        chk("reset_timing", 64'({VGA_H_CNT, VGA_V_CNT, VGA_HS, VGA_VS, VGA_BLANK_N, oFRAME_START}),
            64'({13'd0, 13'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
        chk("reset_rgb", 64'({oVGA_R, oVGA_G, oVGA_B}), 64'd0);
        chk("reset_uf", 64'(oUNDERFLOW), 64'd0);
        repeat (n - 1) @(posedge clk);
        #1;
        rst = 1'b0;
        nh = 0;
        nv = 0;
        src_idx = 0;
        #1;
    endtask

    initial begin
        int fs_cnt, fs_first, fs_last, bn_cnt;
        rst = 1'b1;
        iRGB_VALID = 1'b0;
        {iVGA_R, iVGA_G, iVGA_B} = 24'h0;

        vt[0]  = '{0,  0,  1'b1, 24'hAABBCC, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0};
        vt[1]  = '{2,  0,  1'b1, 24'hAABBCC, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
        vt[2]  = '{4,  0,  1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
        vt[3]  = '{5,  0,  1'b1, 24'hAABBCC, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0};
        vt[4]  = '{7,  1,  1'b1, 24'hAABBCC, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
        vt[5]  = '{3,  2,  1'b1, 24'hAABBCC, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
        vt[6]  = '{10, 3,  1'b1, 24'hAABBCC, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0};
        vt[7]  = '{7,  5,  1'b1, 24'hAABBCC, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0};
        vt[8]  = '{8,  5,  1'b1, 24'h112233, 1'b1, 1'b1, 1'b1, 24'h112233, 1'b0};
        vt[9]  = '{23, 5,  1'b1, 24'h445566, 1'b1, 1'b1, 1'b1, 24'h445566, 1'b0};
        vt[10] = '{12, 7,  1'b0, 24'h123456, 1'b1, 1'b1, 1'b1, 24'hFF00FF, 1'b0};
        vt[11] = '{23, 10, 1'b1, 24'h010203, 1'b1, 1'b1, 1'b1, 24'h010203, 1'b1};

        // Full frame with a well-behaved source
        do_reset(2);
        fs_cnt = 0; fs_first = -1; fs_last = -1; bn_cnt = 0;
        for (int i = 0; i <= FRAME; i++) begin
            step(1'b0, 1'b0, 24'h0);
            chk("timing", 64'({VGA_H_CNT, VGA_V_CNT, VGA_HS, VGA_VS, VGA_BLANK_N, oFRAME_START}),
                64'({13'(mh), 13'(mv), hs_e(mh), vs_e(mv), act_e(mh, mv), (mh == 0 && mv == 0)}));
            chk("rgb", 64'({oVGA_R, oVGA_G, oVGA_B}),
                64'(act_e(mh, mv) ? {iVGA_R, iVGA_G, iVGA_B} : 24'h0));
            chk("uf_clean", 64'(oUNDERFLOW), 64'd0);
            if (oFRAME_START) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                fs_last = i;
            end
            if (i < FRAME && VGA_BLANK_N) bn_cnt++;
        end
        chk("fs_count", 64'(fs_cnt), 64'd2);
        chk("fs_spacing", 64'(fs_last - fs_first), 64'(FRAME));
        chk("active_pixels", 64'(bn_cnt), 64'(H_ACTIVE * V_ACTIVE));
        chk("requests", 64'(src_idx), 64'(H_ACTIVE * V_ACTIVE));

        // Directed vectors across one frame
        do_reset(1);
        for (int k = 0; k < 12; k++) begin
            goto_pos(vt[k].h, vt[k].v);
            step(1'b1, vt[k].valid, vt[k].rgb);
            chk("vec_cnt", 64'({VGA_H_CNT, VGA_V_CNT}), 64'({13'(vt[k].h), 13'(vt[k].v)}));
            chk("vec_sync", 64'({VGA_HS, VGA_VS, VGA_BLANK_N}), 64'({vt[k].hs, vt[k].vs, vt[k].bn}));
            chk("vec_rgb", 64'({oVGA_R, oVGA_G, oVGA_B}), 64'(vt[k].exp_rgb));
            chk("vec_uf", 64'(oUNDERFLOW), 64'(vt[k].uf));
        end

        // Underflow clears on the frame-start edge
        step(1'b0, 1'b0, 24'h0);
        chk("uf_clear_fs", 64'({oFRAME_START, oUNDERFLOW}), 64'({1'b1, 1'b0}));

        // Dropped pixel: fill colour, flag one clock later, held to end of frame
        goto_pos(10, 6);
        step(1'b1, 1'b0, 24'h777777);
        chk("drop_rgb", 64'({oVGA_R, oVGA_G, oVGA_B}), 64'h FF00FF);
        chk("drop_uf_same", 64'(oUNDERFLOW), 64'd0);
        step(1'b0, 1'b0, 24'h0);
        chk("drop_uf_next", 64'(oUNDERFLOW), 64'd1);
        // Drop on the last pixel: set coincides with clear, flag must stay
        goto_pos(23, 10);
        step(1'b1, 1'b0, 24'h0);
        chk("last_drop_uf_held", 64'(oUNDERFLOW), 64'd1);
        step(1'b0, 1'b0, 24'h0);
        chk("set_wins", 64'({oFRAME_START, oUNDERFLOW}), 64'({1'b1, 1'b1}));
        goto_pos(0, 0);
        step(1'b0, 1'b0, 24'h0);
        chk("uf_clear_clean_frame", 64'({oFRAME_START, oUNDERFLOW}), 64'({1'b1, 1'b0}));

        // Mid-frame reset with the flag set
        goto_pos(10, 6);
        step(1'b1, 1'b0, 24'h0);
        goto_pos(14, 8);
        step(1'b0, 1'b0, 24'h0);
        chk("pre_reset_uf", 64'(oUNDERFLOW), 64'd1);
        do_reset(3);
        step(1'b0, 1'b0, 24'h0);
        chk("post_reset_timing", 64'({VGA_H_CNT, VGA_V_CNT, VGA_HS, VGA_VS, VGA_BLANK_N, oFRAME_START}),
            64'({13'd0, 13'd0, 1'b1, 1'b1, 1'b0, 1'b1}));
        chk("post_reset_uf", 64'(oUNDERFLOW), 64'd0);
        step(1'b0, 1'b0, 24'h0);
        chk("post_reset_cnt", 64'({VGA_H_CNT, VGA_V_CNT, oFRAME_START}), 64'({13'd1, 13'd0, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
